// File: rtl/inv_mix_cols_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_cols_iter
//
// Iterative AES InvMixColumns engine for the decryption round. A full 128-bit
// state is accepted over an in_valid/in_ready handshake, transformed
// COLS_PER_CYCLE columns per clock, and then presented on an
// out_valid/out_ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_state is valid this cycle
//   in_ready   block can accept a state this cycle (high only in IDLE)
//   in_state   state to transform, [0:127]; column k = bits [32k:32k+31],
//              byte 0 of a column at the lowest index, bit 0 = byte MSB
//   out_valid  out_state holds a finished result
//   out_ready  consumer accepts out_state
//   out_state  transformed state, same layout as in_state
//   busy       high while computing or holding a result
//
// Parameter:
//   COLS_PER_CYCLE  columns transformed per clock: 1, 2 or 4
// ---------------------------------------------------------------------------
module inv_mix_cols_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the column index that starts the final CALC cycle.
    // With four columns per cycle the step truncates to 0, which is harmless
    // because the single CALC cycle is also the last one.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   col_reg, col_next;
    logic [0:127] work_reg, work_next;
    logic [0:127] result_reg, result_next;
    logic         out_valid_reg, out_valid_next;

    // ---------------------------------------------------------------------
    // GF(2^8) arithmetic, xtime based
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns x*9, x*b, x*d, x*e packed as {m9, mb, md, me}.
    function automatic logic [31:0] mul_set(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_set = {x8 ^ x, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x4 ^ x2};
    endfunction

    // Column word: byte 0 in [31:24], byte 3 in [7:0].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        m0 = mul_set(c[31:24]);
        m1 = mul_set(c[23:16]);
        m2 = mul_set(c[15:8]);
        m3 = mul_set(c[7:0]);
        // field order inside m*: [31:24]=x9 [23:16]=xb [15:8]=xd [7:0]=xe
        inv_mix_col[31:24] = m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24];
        inv_mix_col[23:16] = m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8];
        inv_mix_col[15:8]  = m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16];
        inv_mix_col[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0];
    endfunction

    // ---------------------------------------------------------------------
    // Column lanes: lane gi handles column col_reg + gi this cycle.
    // col_reg is always a multiple of COLS_PER_CYCLE, so lanes never wrap.
    // ---------------------------------------------------------------------
    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] mixed   [COLS_PER_CYCLE];

    genvar gi;
    generate
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            assign col_idx[gi] = col_reg + 2'(gi);
            assign mixed[gi]   = inv_mix_col(work_reg[{col_idx[gi], 5'b0} +: 32]);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        work_next      = work_reg;
        result_next    = result_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_state;
                    col_next   = 2'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    result_next[{col_idx[i], 5'b0} +: 32] = mixed[i];
                end
                if (col_reg == LAST_COL) begin
                    col_next       = 2'd0;
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                end else begin
                    col_next = col_reg + COL_STEP;
                end
            end
            DONE: begin
                // Handoff edge returns to IDLE; in_ready is low this cycle,
                // so a new accept can only happen on the following one.
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                col_next       = 2'd0;
                out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_reg       <= 2'd0;
            work_reg      <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            work_reg      <= work_next;
            result_reg    <= result_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_state = result_reg;

endmodule
